// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// One operand bit is processed per cycle; mthi/mtlo write HI/LO directly when idle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   // The most-negative value maps onto itself, which reads correctly as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic sgn);
      if (sgn && v[WIDTH-1]) begin
         return neg_w(v);
      end else begin
         return v;
      end
   endfunction

   logic [1:0]         state_r, state_nx_s;
   logic [CW-1:0]      count_r;
   logic               op_div_r, neg_lo_r, neg_hi_r;
   logic [WIDTH-1:0]   mcand_r, acc_r, mq_r;
   logic               busy_r, done_r;
   logic [WIDTH-1:0]   hi_r, lo_r;

   logic               is_mul_s, is_div_s, is_signed_s, is_mthi_s, is_mtlo_s;
   logic               idle_s, accept_s, last_s;
   logic               a_neg_s, b_neg_s, b_zero_s;
   logic [WIDTH:0]     add_s, trial_s;
   logic               ge_s;
   logic [WIDTH-1:0]   sub_s;
   logic [WIDTH-1:0]   step_acc_s, step_mq_s, res_hi_s, res_lo_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;

   // Operation decode and request acceptance.
   always_comb begin
      is_mul_s    = 1'b0;
      is_div_s    = 1'b0;
      is_signed_s = 1'b0;
      is_mthi_s   = 1'b0;
      is_mtlo_s   = 1'b0;
      case (funct)
         F_MULT: begin
            is_mul_s    = 1'b1;
            is_signed_s = 1'b1;
         end
         F_MULTU: is_mul_s = 1'b1;
         F_DIV: begin
            is_div_s    = 1'b1;
            is_signed_s = 1'b1;
         end
         F_DIVU:  is_div_s  = 1'b1;
         F_MTHI:  is_mthi_s = 1'b1;
         F_MTLO:  is_mtlo_s = 1'b1;
         default: is_mul_s  = 1'b0;
      endcase
      idle_s   = (state_r == IDLE);
      accept_s = start & idle_s & (is_mul_s | is_div_s);
      a_neg_s  = is_signed_s & srca[WIDTH-1];
      b_neg_s  = is_signed_s & srcb[WIDTH-1];
      b_zero_s = (srcb == ZERO_W);
      last_s   = (state_r == RUN) && (count_r == CNT_ONE);
   end

   // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      add_s   = {1'b0, acc_r} + (mq_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
      trial_s = {acc_r, mq_r[WIDTH-1]};
      ge_s    = (trial_s >= {1'b0, mcand_r});
      sub_s   = trial_s[WIDTH-1:0] - mcand_r;
      if (op_div_r) begin
         if (ge_s) begin
            step_acc_s = sub_s;
            step_mq_s  = {mq_r[WIDTH-2:0], 1'b1};
         end else begin
            step_acc_s = trial_s[WIDTH-1:0];
            step_mq_s  = {mq_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc_s = add_s[WIDTH:1];
         step_mq_s  = {add_s[0], mq_r[WIDTH-1:1]};
      end
      prod_s     = {step_acc_s, step_mq_s};
      prod_fix_s = neg_lo_r ? (~prod_s + ONE_2W) : prod_s;
      if (op_div_r) begin
         res_hi_s = neg_hi_r ? neg_w(step_acc_s) : step_acc_s;
         res_lo_s = neg_lo_r ? neg_w(step_mq_s) : step_mq_s;
      end else begin
         res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_fix_s[WIDTH-1:0];
      end
   end

   // Next-state logic for the IDLE/RUN/FIN sequencer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nx_s = FIN;
            end else begin
               state_nx_s = RUN;
            end
         end
         FIN:     state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Sequencer state, iteration counter and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= CNT_ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s == RUN);
         done_r  <= (state_nx_s == FIN);
         if (accept_s) begin
            count_r <= CNT_LOAD;
         end else if (state_r == RUN) begin
            count_r <= count_r - CNT_ONE;
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Operand capture and iteration registers; a zero divisor keeps the all-ones quotient unsigned.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_div_r <= 1'b0;
         neg_lo_r <= 1'b0;
         neg_hi_r <= 1'b0;
         mcand_r  <= ZERO_W;
         acc_r    <= ZERO_W;
         mq_r     <= ZERO_W;
      end else if (accept_s) begin
         op_div_r <= is_div_s;
         neg_lo_r <= (a_neg_s ^ b_neg_s) & ~(is_div_s & b_zero_s);
         neg_hi_r <= is_div_s & a_neg_s;
         mcand_r  <= mag_w(srcb, is_signed_s);
         acc_r    <= ZERO_W;
         mq_r     <= mag_w(srca, is_signed_s);
      end else if (state_r == RUN) begin
         acc_r <= step_acc_s;
         mq_r  <= step_mq_s;
      end else begin
         acc_r <= acc_r;
         mq_r  <= mq_r;
      end
   end

   // HI/LO: loaded with the final result on the last step, or written directly by mthi/mtlo.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r <= ZERO_W;
         lo_r <= ZERO_W;
      end else if (last_s) begin
         hi_r <= res_hi_s;
         lo_r <= res_lo_s;
      end else begin
         if (idle_s && start && is_mthi_s) begin
            hi_r <= srca;
         end else begin
            hi_r <= hi_r;
         end
         if (idle_s && start && is_mtlo_s) begin
            lo_r <= srca;
         end else begin
            lo_r <= lo_r;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule
